// File: rtl/bsg_decode_one_hot_pipe.sv
// Buffered binary-to-one-hot decoder: two-entry FIFO of indices (plus range-error bit)
// with the one-hot decode driven purely from the registered head entry.
module bsg_decode_one_hot_pipe #(
   parameter  int width_p     = 64,
   localparam int lg_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
   input  logic                   clk_i,
   input  logic                   reset_i,

   input  logic [lg_width_lp-1:0] addr_i,
   input  logic                   v_i,
   output logic                   ready_o,

   output logic [width_p-1:0]     o,
   output logic                   v_o,
   output logic                   err_o,
   input  logic                   yumi_i
);

   localparam logic [31:0] width_lp = 32'(width_p);

   logic [lg_width_lp-1:0] addr_q [2];
   logic                   err_q  [2];
   logic                   head_q, head_d;
   logic                   tail_q, tail_d;
   logic                   empty_q, empty_d;
   logic                   full_q, full_d;
   logic                   ready_q;

   logic                   enq, deq, err_in;
   logic [lg_width_lp-1:0] head_addr;
   logic                   head_err;

   assign enq    = v_i & ready_q;
   // A yumi with nothing buffered is ignored so the pointers never wander.
   assign deq    = yumi_i & ~empty_q;
   assign err_in = (32'(addr_i) >= width_lp);

   always_comb begin
      empty_d = empty_q;
      full_d  = full_q;
      head_d  = head_q ^ deq;
      tail_d  = tail_q ^ enq;
      if (enq & ~deq) begin
         empty_d = 1'b0;
         full_d  = ~empty_q;
      end else if (~enq & deq) begin
         full_d  = 1'b0;
         empty_d = ~full_q;
      end
   end

   // ready_q stays low through reset and rises on the first edge afterwards.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         ready_q <= ~full_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
               addr_q[gi] <= '0;
               err_q[gi]  <= 1'b0;
            end else if (enq && (tail_q == 1'(gi))) begin
               addr_q[gi] <= addr_i;
               err_q[gi]  <= err_in;
            end
         end
      end
   endgenerate

   assign head_addr = addr_q[head_q];
   assign head_err  = err_q[head_q];

   assign ready_o = ready_q;
   assign v_o     = ~empty_q;
   assign err_o   = ~empty_q & head_err;

   generate
      for (gi = 0; gi < width_p; gi++) begin : g_decode
         localparam logic [lg_width_lp-1:0] idx_lp = lg_width_lp'(gi);
         assign o[gi] = ~empty_q & ~head_err & (head_addr == idx_lp);
      end
   endgenerate

endmodule

// File: tb/tb_bsg_decode_one_hot_pipe.sv
// Bench for bsg_decode_one_hot_pipe: three instances (width 64, 48, 1) checked every
// cycle against a two-slot occupancy model, plus literal expectations per scenario.
module tb_bsg_decode_one_hot_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [5:0]  addr  [3];
   logic        v_in  [3];
   logic        yumi  [3];
   logic        rdy   [3];
   logic        vo    [3];
   logic        eo    [3];
   logic [63:0] ow    [3];

   logic [63:0] o64;
   logic [47:0] o48;
   logic [0:0]  o1;
   logic [0:0]  a1;

   assign a1    = addr[2][0:0];
   assign ow[0] = o64;
   assign ow[1] = {16'b0, o48};
   assign ow[2] = {63'b0, o1};

   bsg_decode_one_hot_pipe #(.width_p(64)) u64 (
      .clk_i(clk), .reset_i(rst), .addr_i(addr[0]), .v_i(v_in[0]), .ready_o(rdy[0]),
      .o(o64), .v_o(vo[0]), .err_o(eo[0]), .yumi_i(yumi[0]));
   bsg_decode_one_hot_pipe #(.width_p(48)) u48 (
      .clk_i(clk), .reset_i(rst), .addr_i(addr[1]), .v_i(v_in[1]), .ready_o(rdy[1]),
      .o(o48), .v_o(vo[1]), .err_o(eo[1]), .yumi_i(yumi[1]));
   bsg_decode_one_hot_pipe #(.width_p(1)) u1 (
      .clk_i(clk), .reset_i(rst), .addr_i(a1), .v_i(v_in[2]), .ready_o(rdy[2]),
      .o(o1), .v_o(vo[2]), .err_o(eo[2]), .yumi_i(yumi[2]));

   int checks = 0;
   int errors = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Model: per instance, a list of buffered indices (head first) and the ready flag.
   int widths [3] = '{64, 48, 1};
   int cnt    [3] = '{0, 0, 0};
   int ent0   [3] = '{0, 0, 0};
   int ent1   [3] = '{0, 0, 0};
   bit mrdy   [3] = '{0, 0, 0};

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 3; k++) begin
         int c, e0, e1, a;
         bit enq, deq;
         c = cnt[k]; e0 = ent0[k]; e1 = ent1[k];
         a = (k == 2) ? int'(addr[2][0]) : int'(addr[k]);
         if (rst) begin
            cnt[k]  <= 0;
            mrdy[k] <= 1'b0;
         end else begin
            enq = v_in[k] && mrdy[k];
            deq = yumi[k] && (c > 0);
            if (deq) begin e0 = e1; c = c - 1; end
            if (enq) begin
               if (c == 0) e0 = a; else e1 = a;
               c = c + 1;
            end
            cnt[k]  <= c;
            ent0[k] <= e0;
            ent1[k] <= e1;
            mrdy[k] <= (c < 2);
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         bit          ev, ee;
         logic [63:0] eo_v;
         ev   = cnt[k] > 0;
         ee   = ev && (ent0[k] >= widths[k]);
         eo_v = (ev && !ee) ? (64'd1 << ent0[k]) : 64'd0;
         chk($sformatf("model_v_o[w%0d]", widths[k]),     64'(vo[k]),  64'(ev));
         chk($sformatf("model_err_o[w%0d]", widths[k]),   64'(eo[k]),  64'(ee));
         chk($sformatf("model_o[w%0d]", widths[k]),       ow[k],       eo_v);
         chk($sformatf("model_ready_o[w%0d]", widths[k]), 64'(rdy[k]), 64'(mrdy[k]));
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++)
         if (!rst) assert (!(yumi[k] && !vo[k])) else $error("yumi_i without v_o on instance %0d", k);
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   function automatic int oh_idx(logic [63:0] x);
      for (int i = 0; i < 64; i++) if (x[i]) return i;
      return -1;
   endfunction

   task automatic xfer(int k, logic [5:0] a, logic [63:0] exp_o, logic exp_err);
      v_in[k] = 1'b1; addr[k] = a;
      cyc();
      v_in[k] = 1'b0;
      chk($sformatf("xfer_v_o[w%0d,%0d]", widths[k], a), 64'(vo[k]), 64'd1);
      chk($sformatf("xfer_o[w%0d,%0d]", widths[k], a), ow[k], exp_o);
      chk($sformatf("xfer_err[w%0d,%0d]", widths[k], a), 64'(eo[k]), 64'(exp_err));
      $display("xfer w%0d idx %0d -> o=%h err=%0b", widths[k], a, ow[k], eo[k]);
      yumi[k] = 1'b1;
      cyc();
      yumi[k] = 1'b0;
      chk($sformatf("xfer_drain[w%0d,%0d]", widths[k], a), 64'(vo[k]), 64'd0);
   endtask

   initial begin
      int next_exp;
      bit rdy_dropped;
      bit acc;
      int got [$];

      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         addr[k] = '0; v_in[k] = 1'b0; yumi[k] = 1'b0;
      end
      cyc(); cyc();
      chk("reset_ready", 64'(rdy[0]), 64'd0);
      chk("reset_v_o",   64'(vo[0]),  64'd0);
      v_in[0] = 1'b1; addr[0] = 6'd3;
      cyc();
      v_in[0] = 1'b0;
      rst = 1'b0;
      #1 chk("ready_before_edge", 64'(rdy[0]), 64'd0);
      cyc();
      chk("ready_after_reset", 64'(rdy[0]), 64'd1);
      chk("no_enq_in_reset",   64'(vo[0]),  64'd0);

      // single transfer with hold
      v_in[0] = 1'b1; addr[0] = 6'd37;
      cyc();
      v_in[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("single_o_hold", o64, 64'h0000_0020_0000_0000);
         chk("single_v_hold", 64'(vo[0]), 64'd1);
         cyc();
      end
      $display("single idx 37 -> o=%h", o64);
      yumi[0] = 1'b1;
      cyc();
      yumi[0] = 1'b0;
      chk("single_drain_v", 64'(vo[0]), 64'd0);
      chk("single_drain_o", o64, 64'd0);

      // streaming 0..63
      next_exp = 0; rdy_dropped = 1'b0;
      for (int i = 0; i < 64 + 3; i++) begin
         v_in[0] = (i < 64); addr[0] = 6'(i);
         yumi[0] = vo[0];
         if (!rdy[0]) rdy_dropped = 1'b1;
         if (vo[0]) begin
            chk("stream_o", o64, 64'd1 << next_exp);
            chk("stream_err", 64'(eo[0]), 64'd0);
            $display("stream idx %0d -> o=%h", next_exp, o64);
            next_exp++;
         end
         cyc();
      end
      v_in[0] = 1'b0; yumi[0] = 1'b0;
      chk("stream_count", 64'(next_exp), 64'd64);
      chk("stream_ready_dropped", 64'(rdy_dropped), 64'd0);

      // backpressure 5, 9, 12
      v_in[0] = 1'b1; addr[0] = 6'd5; cyc();
      addr[0] = 6'd9; cyc();
      chk("bp_ready_full", 64'(rdy[0]), 64'd0);
      addr[0] = 6'd12; cyc(); cyc();
      for (int n = 0; n < 20 && got.size() < 4; n++) begin
         acc = rdy[0] && v_in[0];
         yumi[0] = vo[0];
         if (vo[0]) begin
            got.push_back(oh_idx(o64));
            $display("bp out idx %0d", oh_idx(o64));
         end
         cyc();
         if (acc) v_in[0] = 1'b0;
         if (!vo[0] && !v_in[0]) break;
      end
      yumi[0] = 1'b0; v_in[0] = 1'b0;
      chk("bp_count", 64'(got.size()), 64'd3);
      while (got.size() < 3) got.push_back(-1);
      chk("bp_first",  64'(got[0]), 64'd5);
      chk("bp_second", 64'(got[1]), 64'd9);
      chk("bp_third",  64'(got[2]), 64'd12);

      // reset mid-stream with FULL buffer
      v_in[0] = 1'b1; addr[0] = 6'd3; cyc();
      addr[0] = 6'd7; cyc();
      v_in[0] = 1'b0;
      chk("pre_reset_full", 64'(rdy[0]), 64'd0);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_v_o",   64'(vo[0]),  64'd0);
      chk("async_rst_o",     o64,         64'd0);
      chk("async_rst_err",   64'(eo[0]),  64'd0);
      chk("async_rst_ready", 64'(rdy[0]), 64'd0);
      $display("reset mid-stream applied");
      cyc();
      rst = 1'b0;
      cyc();
      chk("post_rst_ready", 64'(rdy[0]), 64'd1);
      cyc();
      chk("post_rst_no_stale", 64'(vo[0]), 64'd0);

      // width 48 range edges, width 1 corner
      xfer(1, 6'd47, 64'h0000_8000_0000_0000, 1'b0);
      xfer(1, 6'd48, 64'd0, 1'b1);
      xfer(1, 6'd63, 64'd0, 1'b1);
      xfer(2, 6'd0, 64'd1, 1'b0);
      xfer(2, 6'd1, 64'd0, 1'b1);

      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bsg_decode_one_hot_pipe.md
# bsg_decode_one_hot_pipe

Buffered binary-to-one-hot decoder, the inverse of the one-hot encoder in `bsg_misc`. It accepts a binary index on a valid/ready input and presents the matching one-hot vector on a valid/yumi output. A two-entry internal buffer gives full throughput and registered outputs. It sits between an arbiter or address generator that produces indices and consumers that need one-hot selects: grant lines, write-enable fans, mux selects.

## Interface
- `width_p`, default 64: one-hot output width; any value ≥ 1, not restricted to powers of two.
- `lg_width_lp`, derived as max(1, ceil(log2(width_p))): index width. Not overridable.
- One clock; reset is asynchronous and active-high.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `reset_i`  in  1  asynchronous active-high reset.
- `addr_i`  in  `lg_width_lp`  binary index to decode.
- `v_i`  in  1  `addr_i` valid.
- `ready_o`  out  1  buffer can accept an entry this cycle.
- `o`  out  `width_p`  one-hot decode of the head entry; all zeros when `v_o`=0.
- `v_o`  out  1  head entry valid.
- `err_o`  out  1  head entry index ≥ `width_p`; only meaningful while `v_o`=1, else 0.
- `yumi_i`  in  1  consumer takes the head entry; legal only when `v_o`=1.

## Operation
- Storage: two entries of (`lg_width_lp` index + 1 error bit), with head/tail pointers and full/empty flags, organized as a two-element FIFO.
- Enqueue when `v_i & ready_o`. The error bit is computed at enqueue as (`addr_i` ≥ `width_p`).
- Dequeue when `yumi_i`. The head pointer advances.
- Decode from the head entry, driven from registered state only, with no combinational path from any input:
  - `o[k]` = 1 iff `v_o`, the index equals k, and the error bit is 0.
  - An out-of-range index gives `o` = all zeros with `err_o`=1.
- Occupancy states:
  - EMPTY: `v_o`=0, `ready_o`=1.
  - ONE: `v_o`=1, `ready_o`=1.
  - FULL: `v_o`=1, `ready_o`=0.
- Transitions, with enq = `v_i & ready_o` and deq = `yumi_i`:
  - EMPTY: enq → ONE.
  - ONE: enq & !deq → FULL; !enq & deq → EMPTY; enq & deq → ONE, new entry becomes head next cycle.
  - FULL: deq → ONE; enq impossible.
- `ready_o` depends only on occupancy, never on `yumi_i`. No same-cycle enqueue into a full buffer, even when the consumer dequeues that cycle.
- Protocol violations:
  - `yumi_i` while `v_o`=0 is illegal. The bench asserts on it. RTL ignores it: no pointer movement.
  - `v_i` while `ready_o`=0 is dropped silently. The producer must hold.
- `width_p`=1: `lg_width_lp`=1. Index 0 gives `o`=1'b1. Index 1 sets `err_o`.
- Non-power-of-two `width_p`: indices `width_p` … 2^`lg_width_lp`−1 set `err_o`.

## Timing
- Reset, asynchronous and effective immediately, even mid-operation: both entries discarded; pointers to 0; `v_o`=0, `o`=0, `err_o`=0, `ready_o`=0.
- `ready_o` rises in the first cycle after `reset_i` deasserts.
- No enqueue is accepted while `reset_i`=1.
- Latency: an index accepted on edge N is visible on `o`/`v_o`/`err_o` immediately after edge N, i.e. in the cycle following acceptance. There is no bypass in the acceptance cycle.
- Throughput: one index per cycle sustained when `yumi_i` is asserted every cycle `v_o`=1.
- Backpressure: with `yumi_i`=0, two entries are absorbed and `ready_o` drops in the cycle after the second acceptance.
- Outputs change only on clock edges or reset assertion.

## Test plan
- Reset mid-stream: fill to FULL (indices 3, 7). Assert `reset_i` between edges. Then `v_o`, `o`, `err_o`, and `ready_o` go to 0 without a clock edge. After deassert, `ready_o`=1 and no stale entry appears.
- Single transfer, `width_p`=64: `addr_i`=37, `v_i`=1 for one cycle. Next cycle `v_o`=1 and `o`=1<<37. Hold `yumi_i`=0 for 3 cycles and `o` stays stable. Pulse `yumi_i`, then `v_o`=0 and `o`=0.
- Streaming: indices 0,1,…,63 back-to-back with `yumi_i`=`v_o`. The output sequence is 1<<0 … 1<<63 on consecutive cycles, `ready_o` never drops, and `err_o` stays 0.
- Backpressure: `yumi_i`=0 while offering 5, 9, 12. 5 and 9 are accepted. `ready_o`=0 so 12 is held. Release `yumi_i`: output order is 5, 9, 12 with no loss or duplication.
- Out-of-range, `width_p`=48: `addr_i`=47 gives `o`=1<<47 with `err_o`=0. `addr_i`=48 and then 63 each give `o`=0 with `err_o`=1 and `v_o`=1.
- Corner `width_p`=1: index 0 gives `o`=1 with `err_o`=0. Index 1 gives `o`=0 with `err_o`=1.
